// File: rtl/rt_block_sampler_pkg.sv
// Shared constants for the real-time block sampler: device offsets, block size, index decode.
// Latency: n/a (pure constants and combinational helper functions).
// Backpressure: n/a.
package rt_block_sampler_pkg;

  // Board-level (channel 0) register offsets
  localparam logic [3:0] OFF_STATUS  = 4'h0;
  localparam logic [3:0] OFF_TEMP    = 4'h3;
  localparam logic [3:0] OFF_DIGIO   = 4'hA;
  // Per-motor offsets
  localparam logic [3:0] OFF_ADC     = 4'h0;
  localparam logic [3:0] OFF_MSTAT   = 4'hC;
  // Per-encoder offsets, contiguous POS..RUN
  localparam logic [3:0] OFF_ENC_POS  = 4'h4;
  localparam logic [3:0] OFF_ENC_VEL  = 4'h5;
  localparam logic [3:0] OFF_ENC_QTR1 = 4'h6;
  localparam logic [3:0] OFF_ENC_QTR5 = 4'h7;
  localparam logic [3:0] OFF_ENC_RUN  = 4'h8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Quadlets per block: timestamp + 3 board quadlets + 2 per motor + 5 per encoder.
  function automatic int nq(input int nm, input int ne);
    return 4 + 2 * nm + 5 * ne;
  endfunction

  // Block index -> {chan, off}. Index 0 (timestamp) never reaches the bus.
  function automatic logic [7:0] blk_addr(input logic [7:0] idx, input int nm);
    int i;
    int j;
    logic [3:0] ch;
    logic [3:0] off;
    i   = int'(idx);
    ch  = 4'h0;
    off = OFF_STATUS;
    if (i == 2) begin
      off = OFF_DIGIO;
    end else if (i == 3) begin
      off = OFF_TEMP;
    end else if (i >= 4 && i < 4 + 2 * nm) begin
      j   = i - 4;
      ch  = 4'(j / 2 + 1);
      off = (j % 2 == 1) ? OFF_MSTAT : OFF_ADC;
    end else if (i >= 4 + 2 * nm) begin
      j   = i - 4 - 2 * nm;
      ch  = 4'(j / 5 + 1);
      off = OFF_ENC_POS + 4'(j % 5);
    end
    return {ch, off};
  endfunction

endpackage

// File: rtl/rt_block_sampler_if.sv
// Bus bundle between the sampler, the board register read mux and the block-read logic.
// Latency: n/a (wires only).
// Backpressure: none; reg_rdata follows reg_raddr after a fixed latency.
// Ports: sample_start/timestamp (request), reg_raddr/reg_rdata (register sweep),
//        sample_busy/chan/done/overrun (status), sample_raddr/sample_rdata (block readout).
interface rt_block_sampler_if #(
  parameter int ADDR_WIDTH = 6
);
  logic                  sample_start;
  logic [31:0]           timestamp;
  logic [15:0]           reg_raddr;
  logic [31:0]           reg_rdata;
  logic                  sample_busy;
  logic [3:0]            sample_chan;
  logic                  sample_done;
  logic                  sample_overrun;
  logic [ADDR_WIDTH-1:0] sample_raddr;
  logic [31:0]           sample_rdata;

  // master: the sampler itself
  modport master (
    input  sample_start, timestamp, reg_rdata, sample_raddr,
    output reg_raddr, sample_busy, sample_chan, sample_done, sample_overrun, sample_rdata
  );

  // slave: the surrounding board/host logic
  modport slave (
    output sample_start, timestamp, reg_rdata, sample_raddr,
    input  reg_raddr, sample_busy, sample_chan, sample_done, sample_overrun, sample_rdata
  );
endinterface

// File: rtl/rt_block_sampler_dbuf.sv
// Double-buffered block store: write into one bank while the reader sees the other.
// Latency: read data registered, 1 cycle after rd_addr; swap takes effect for the read in the swap cycle.
// Backpressure: none; single write port, always-ready read port.
// Ports: clk/rst, wr_en/wr_addr/wr_data (write bank), swap, rd_addr/rd_data (read bank).
module rt_block_sampler_dbuf #(
  parameter int ADDR_WIDTH = 6,
  parameter int NQ         = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [31:0]           wr_data_i,
  input  logic                  swap_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [31:0]           rd_data_o
);
  logic [31:0] mem_q [2**(ADDR_WIDTH+1)];
  logic        bank_q;    // current read bank; write bank is its complement
  logic        rd_bank;
  logic [31:0] rdata_q;

  // Reading through the post-swap bank in the swap cycle makes the new block
  // appear on rd_data exactly one cycle after the done pulse.
  assign rd_bank = swap_i ? ~bank_q : bank_q;

  // Contents survive reset on purpose: the last completed block stays readable.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[{~bank_q, wr_addr_i}] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_q  <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      if (swap_i) begin
        bank_q <= ~bank_q;
      end
      // Entries beyond the block are never written; present them as zero.
      rdata_q <= (int'(rd_addr_i) < NQ) ? mem_q[{rd_bank, rd_addr_i}] : 32'h0;
    end
  end

  assign rd_data_o = rdata_q;
endmodule

// File: rtl/rt_block_sampler.sv
// Timestamps and sweeps one real-time read block into a double buffer on each start.
// Latency: start-to-done NQ+RD_LATENCY cycles; readout 1 cycle after sample_raddr.
// Backpressure: none; a start while busy is dropped and flagged on sample_overrun.
// Ports: sysclk/reset plain; everything else on bus (rt_block_sampler_if.master).
module rt_block_sampler #(
  parameter int NUM_MOTORS   = 4,
  parameter int NUM_ENCODERS = 4,
  parameter int RD_LATENCY   = 1,
  parameter int ADDR_WIDTH   = 6
) (
  input  logic               sysclk,
  input  logic               reset,
  rt_block_sampler_if.master bus
);
  import rt_block_sampler_pkg::*;

  localparam int         NQ       = nq(NUM_MOTORS, NUM_ENCODERS);
  localparam logic [7:0] LAST_IDX = 8'(NQ - 1);
  localparam logic [1:0] LAT      = 2'(RD_LATENCY);

  state_e      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] raddr_q, raddr_d;
  logic [3:0]  chan_q, chan_d;
  logic        ovr_q, ovr_d;
  logic        start_acc;
  logic        issue;
  logic        done;
  logic        busy;
  logic [7:0]  next_addr;

  // Capture pipeline: tracks which index the returning reg_rdata belongs to.
  logic        vld_pipe_q [RD_LATENCY];
  logic [7:0]  idx_pipe_q [RD_LATENCY];

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;

  assign issue = (state_q == ST_ISSUE);
  // DRAIN runs RD_LATENCY+1 cycles; its last cycle is the done cycle, where busy is already low.
  assign done  = (state_q == ST_DRAIN) && (cnt_q == LAT);
  assign busy  = issue || ((state_q == ST_DRAIN) && (cnt_q != LAT));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    ovr_d     = ovr_q;
    start_acc = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.sample_start) begin
          start_acc = 1'b1;
          ovr_d     = 1'b0;
          idx_d     = 8'd1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.sample_start) ovr_d = 1'b1;
        if (idx_q == LAST_IDX) begin
          cnt_d   = 2'd0;
          state_d = ST_DRAIN;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end
      ST_DRAIN: begin
        if (bus.sample_start) ovr_d = 1'b1;
        if (cnt_q == LAT) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address for the index being issued next cycle; bus returns to 0 outside ISSUE.
  assign next_addr = blk_addr(idx_d, NUM_MOTORS);

  always_comb begin
    raddr_d = 16'h0000;
    chan_d  = 4'h0;
    if (state_d == ST_ISSUE) begin
      raddr_d = {8'h00, next_addr};
      chan_d  = next_addr[7:4];
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 8'd0;
      cnt_q   <= 2'd0;
      raddr_q <= 16'h0000;
      chan_q  <= 4'h0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      raddr_q <= raddr_d;
      chan_q  <= chan_d;
      ovr_q   <= ovr_d;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      for (int k = 0; k < RD_LATENCY; k++) vld_pipe_q[k] <= 1'b0;
    end else begin
      vld_pipe_q[0] <= issue;
      idx_pipe_q[0] <= idx_q;
      for (int k = 1; k < RD_LATENCY; k++) begin
        vld_pipe_q[k] <= vld_pipe_q[k-1];
        idx_pipe_q[k] <= idx_pipe_q[k-1];
      end
    end
  end

  // Timestamp write (start cycle, IDLE) and bus captures (during sweep) never coincide.
  assign wr_en   = start_acc || vld_pipe_q[RD_LATENCY-1];
  assign wr_addr = ADDR_WIDTH'(start_acc ? 8'd0 : idx_pipe_q[RD_LATENCY-1]);
  assign wr_data = start_acc ? bus.timestamp : bus.reg_rdata;

  rt_block_sampler_dbuf #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NQ         (NQ)
  ) u_dbuf (
    .clk_i     (sysclk),
    .rst_i     (reset),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .swap_i    (done),
    .rd_addr_i (bus.sample_raddr),
    .rd_data_o (bus.sample_rdata)
  );

  assign bus.reg_raddr      = raddr_q;
  assign bus.sample_chan    = chan_q;
  assign bus.sample_busy    = busy;
  assign bus.sample_done    = done;
  assign bus.sample_overrun = ovr_q;
endmodule

// File: tb/tb_rt_block_sampler.sv
// Directed bench for rt_block_sampler: default block (A) and 8/8/L=3 block (B).
// Latency: register read data modelled with a fixed RD_LATENCY delay per instance.
// Backpressure: none.
module tb_rt_block_sampler;
  logic        sysclk = 1'b0;
  logic        reset  = 1'b1;
  logic [15:0] hi_a   = 16'hA5A5;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #10 sysclk = ~sysclk;

  rt_block_sampler_if #(.ADDR_WIDTH(6)) bus_a ();
  rt_block_sampler_if #(.ADDR_WIDTH(7)) bus_b ();

  rt_block_sampler #(.NUM_MOTORS(4), .NUM_ENCODERS(4), .RD_LATENCY(1), .ADDR_WIDTH(6))
    dut_a (.sysclk(sysclk), .reset(reset), .bus(bus_a));
  rt_block_sampler #(.NUM_MOTORS(8), .NUM_ENCODERS(8), .RD_LATENCY(3), .ADDR_WIDTH(7))
    dut_b (.sysclk(sysclk), .reset(reset), .bus(bus_b));

  // Register mux models: data = {hi, address}, delayed by the instance latency.
  logic [31:0] pb1, pb2;
  always @(posedge sysclk) begin
    bus_a.reg_rdata <= {hi_a, bus_a.reg_raddr};
    pb1             <= {16'hA5A5, bus_b.reg_raddr};
    pb2             <= pb1;
    bus_b.reg_rdata <= pb2;
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic read_a(input int idx, output logic [31:0] v);
    bus_a.sample_raddr = 6'(idx);
    tick();
    v = bus_a.sample_rdata;
  endtask

  task automatic read_b(input int idx, output logic [31:0] v);
    bus_b.sample_raddr = 7'(idx);
    tick();
    v = bus_b.sample_rdata;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++; if (bus_a.sample_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", bus_a.sample_busy); end
    n_checks++; if (bus_a.sample_done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", bus_a.sample_done); end
    n_checks++; if (bus_a.sample_overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun got %b want 0", bus_a.sample_overrun); end
    n_checks++; if (bus_a.sample_chan !== 4'h0) begin n_fail++; $display("FAIL rst_chan got %h want 0", bus_a.sample_chan); end
    n_checks++; if (bus_a.reg_raddr !== 16'h0) begin n_fail++; $display("FAIL rst_raddr got %h want 0", bus_a.reg_raddr); end
    n_checks++; if (bus_a.sample_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h want 0", bus_a.sample_rdata); end
    n_checks++; if (bus_b.sample_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy_b got %b want 0", bus_b.sample_busy); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int busy_cnt;
    int done_cnt;
    int done_at;
    logic [31:0] v;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    hi_a = 16'hA5A5;
    bus_a.timestamp = 32'h12345678;
    bus_a.sample_start = 1'b1;
    tick();
    bus_a.sample_start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (bus_a.sample_busy === 1'b1) busy_cnt++;
      if (bus_a.sample_done === 1'b1) begin done_cnt++; done_at = k; end
      if (k == 2) begin
        n_checks++; if (bus_a.reg_raddr !== 16'h000A) begin n_fail++; $display("FAIL basic_raddr2 got %h want 000a", bus_a.reg_raddr); end
      end
      if (k == 4) begin
        n_checks++; if (bus_a.reg_raddr !== 16'h0010) begin n_fail++; $display("FAIL basic_raddr4 got %h want 0010", bus_a.reg_raddr); end
      end
      if (k == 31) begin
        n_checks++; if (bus_a.reg_raddr !== 16'h0048) begin n_fail++; $display("FAIL basic_raddr31 got %h want 0048", bus_a.reg_raddr); end
        n_checks++; if (bus_a.sample_chan !== 4'h4) begin n_fail++; $display("FAIL basic_chan31 got %h want 4", bus_a.sample_chan); end
      end
      if (k == 32) begin
        n_checks++; if (bus_a.reg_raddr !== 16'h0000) begin n_fail++; $display("FAIL basic_raddr_idle got %h want 0", bus_a.reg_raddr); end
      end
      tick();
    end
    n_checks++; if (busy_cnt != 32) begin n_fail++; $display("FAIL basic_busy_cycles got %0d want 32", busy_cnt); end
    n_checks++; if (done_at != 33) begin n_fail++; $display("FAIL basic_done_cycle got %0d want 33", done_at); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL basic_done_pulses got %0d want 1", done_cnt); end
    read_a(0, v);  n_checks++; if (v !== 32'h12345678) begin n_fail++; $display("FAIL basic_buf0 got %h want 12345678", v); end
    read_a(4, v);  n_checks++; if (v !== 32'hA5A50010) begin n_fail++; $display("FAIL basic_buf4 got %h want a5a50010", v); end
    read_a(5, v);  n_checks++; if (v !== 32'hA5A5001C) begin n_fail++; $display("FAIL basic_buf5 got %h want a5a5001c", v); end
    read_a(31, v); n_checks++; if (v !== 32'hA5A50048) begin n_fail++; $display("FAIL basic_buf31 got %h want a5a50048", v); end
    read_a(2, v);  n_checks++; if (v !== 32'hA5A5000A) begin n_fail++; $display("FAIL basic_buf2 got %h want a5a5000a", v); end
    read_a(40, v); n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL basic_buf40 got %h want 0", v); end
  endtask

  task automatic test_double_buffer();
    logic [31:0] exp;
    logic [31:0] v;
    hi_a = 16'h5A5A;
    bus_a.sample_raddr = 6'd4;
    tick();
    bus_a.timestamp = 32'h0BADF00D;
    bus_a.sample_start = 1'b1;
    tick();
    bus_a.sample_start = 1'b0;
    for (int k = 1; k <= 36; k++) begin
      exp = (k <= 33) ? 32'hA5A50010 : 32'h5A5A0010;
      n_checks++;
      if (bus_a.sample_rdata !== exp) begin
        n_fail++; $display("FAIL dbuf_read4 cycle T+%0d got %h want %h", k, bus_a.sample_rdata, exp);
      end
      tick();
    end
    read_a(0, v); n_checks++; if (v !== 32'h0BADF00D) begin n_fail++; $display("FAIL dbuf_buf0 got %h want 0badf00d", v); end
    read_a(5, v); n_checks++; if (v !== 32'h5A5A001C) begin n_fail++; $display("FAIL dbuf_buf5 got %h want 5a5a001c", v); end
  endtask

  task automatic test_reset_mid();
    int busy_cnt;
    int done_cnt;
    logic [31:0] v;
    busy_cnt = 0; done_cnt = 0;
    read_a(0, v); n_checks++; if (v !== 32'h0BADF00D) begin n_fail++; $display("FAIL rmid_pre got %h want 0badf00d", v); end
    bus_a.timestamp = 32'hDEAD0001;
    bus_a.sample_start = 1'b1;
    tick();
    bus_a.sample_start = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    reset = 1'b1;
    tick();
    n_checks++; if (bus_a.sample_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b want 0", bus_a.sample_busy); end
    n_checks++; if (bus_a.sample_done !== 1'b0) begin n_fail++; $display("FAIL rmid_done got %b want 0", bus_a.sample_done); end
    n_checks++; if (bus_a.reg_raddr !== 16'h0) begin n_fail++; $display("FAIL rmid_raddr got %h want 0", bus_a.reg_raddr); end
    n_checks++; if (bus_a.sample_chan !== 4'h0) begin n_fail++; $display("FAIL rmid_chan got %h want 0", bus_a.sample_chan); end
    n_checks++; if (bus_a.sample_rdata !== 32'h0) begin n_fail++; $display("FAIL rmid_rdata got %h want 0", bus_a.sample_rdata); end
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus_a.sample_done === 1'b1) done_cnt++;
      if (bus_a.sample_busy === 1'b1) busy_cnt++;
      tick();
    end
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL rmid_no_done got %0d want 0", done_cnt); end
    n_checks++; if (busy_cnt != 0) begin n_fail++; $display("FAIL rmid_no_busy got %0d want 0", busy_cnt); end
    read_a(0, v); n_checks++; if (v !== 32'h0BADF00D) begin n_fail++; $display("FAIL rmid_buf0 got %h want 0badf00d", v); end
    read_a(4, v); n_checks++; if (v !== 32'h5A5A0010) begin n_fail++; $display("FAIL rmid_buf4 got %h want 5a5a0010", v); end
  endtask

  task automatic test_overrun();
    int k;
    int done_cnt;
    done_cnt = 0;
    bus_a.timestamp = 32'h00000001;
    bus_a.sample_start = 1'b1;
    tick();
    bus_a.sample_start = 1'b0;
    n_checks++; if (bus_a.sample_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_initial got %b want 0", bus_a.sample_overrun); end
    for (int j = 1; j < 5; j++) tick();
    bus_a.sample_start = 1'b1;
    tick();
    bus_a.sample_start = 1'b0;
    n_checks++; if (bus_a.sample_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set got %b want 1", bus_a.sample_overrun); end
    n_checks++; if (bus_a.reg_raddr !== 16'h0020) begin n_fail++; $display("FAIL ovr_sweep_raddr6 got %h want 0020", bus_a.reg_raddr); end
    k = 6;
    while (bus_a.sample_done !== 1'b1 && k < 45) begin
      tick();
      k++;
    end
    n_checks++; if (k != 33) begin n_fail++; $display("FAIL ovr_done_cycle got %0d want 33", k); end
    bus_a.sample_start = 1'b1;
    tick();
    bus_a.sample_start = 1'b0;
    n_checks++; if (bus_a.sample_busy !== 1'b0) begin n_fail++; $display("FAIL ovr_done_start_busy got %b want 0", bus_a.sample_busy); end
    n_checks++; if (bus_a.sample_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_done_start_flag got %b want 1", bus_a.sample_overrun); end
    tick();
    n_checks++; if (bus_a.sample_busy !== 1'b0) begin n_fail++; $display("FAIL ovr_idle_busy got %b want 0", bus_a.sample_busy); end
    bus_a.sample_start = 1'b1;
    tick();
    bus_a.sample_start = 1'b0;
    n_checks++; if (bus_a.sample_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %b want 0", bus_a.sample_overrun); end
    n_checks++; if (bus_a.sample_busy !== 1'b1) begin n_fail++; $display("FAIL ovr_restart_busy got %b want 1", bus_a.sample_busy); end
    for (int j = 0; j < 40; j++) begin
      if (bus_a.sample_done === 1'b1) done_cnt++;
      tick();
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL ovr_restart_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_big();
    int busy_cnt;
    int done_at;
    logic [31:0] v;
    busy_cnt = 0; done_at = 0;
    bus_b.timestamp = 32'hCAFE0000;
    bus_b.sample_start = 1'b1;
    tick();
    bus_b.sample_start = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      if (bus_b.sample_busy === 1'b1) busy_cnt++;
      if (bus_b.sample_done === 1'b1) done_at = k;
      if (k == 59) begin
        n_checks++; if (bus_b.reg_raddr !== 16'h0088) begin n_fail++; $display("FAIL big_raddr59 got %h want 0088", bus_b.reg_raddr); end
        n_checks++; if (bus_b.sample_chan !== 4'h8) begin n_fail++; $display("FAIL big_chan59 got %h want 8", bus_b.sample_chan); end
      end
      tick();
    end
    n_checks++; if (busy_cnt != 62) begin n_fail++; $display("FAIL big_busy_cycles got %0d want 62", busy_cnt); end
    n_checks++; if (done_at != 63) begin n_fail++; $display("FAIL big_done_cycle got %0d want 63", done_at); end
    read_b(59, v); n_checks++; if (v !== 32'hA5A50088) begin n_fail++; $display("FAIL big_buf59 got %h want a5a50088", v); end
    read_b(20, v); n_checks++; if (v !== 32'hA5A50014) begin n_fail++; $display("FAIL big_buf20 got %h want a5a50014", v); end
    read_b(0, v);  n_checks++; if (v !== 32'hCAFE0000) begin n_fail++; $display("FAIL big_buf0 got %h want cafe0000", v); end
    read_b(60, v); n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL big_buf60 got %h want 0", v); end
  endtask

  initial begin
    bus_a.sample_start = 1'b0;
    bus_a.timestamp    = 32'h0;
    bus_a.sample_raddr = 6'd0;
    bus_b.sample_start = 1'b0;
    bus_b.timestamp    = 32'h0;
    bus_b.sample_raddr = 7'd0;
    test_reset();
    test_basic();
    test_double_buffer();
    test_reset_mid();
    test_overrun();
    test_big();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at time %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
